// File: rtl/fu_div_radix2.sv
// rtl/fu_div_radix2.sv - iterative RV32M DIV/DIVU/REM/REMU unit, restoring radix-2
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at start.
module fu_div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        finish,
  output logic        busy,
  output logic [31:0] res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;

  // Start-cycle decode of the incoming operands
  logic        in_signed;
  logic        in_rem;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic        sgn_ovf;

  always_comb begin
    in_signed = ~op[0];
    in_rem    = op[1];
    a_mag     = (in_signed && A[31]) ? (32'd0 - A) : A;
    b_mag     = (in_signed && B[31]) ? (32'd0 - B) : B;
    b_zero    = (B == 32'd0);
    sgn_ovf   = in_signed && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  end

  // One restoring step; the extra top bit makes the trial sign visible
  logic [33:0] rem_sh;
  logic [33:0] trial;
  logic        trial_ge;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    trial    = rem_sh - {2'b00, dvs_q};
    trial_ge = ~trial[33];
    rem_nx   = trial_ge ? trial[32:0] : rem_sh[32:0];
    quo_nx   = {quo_q[30:0], trial_ge};
    quo_res  = qneg_q ? (32'd0 - quo_nx) : quo_nx;
    rem_res  = rneg_q ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (EN) begin
          op_d   = op;
          qneg_d = in_signed && (A[31] ^ B[31]);
          rneg_d = in_signed && A[31];
          dvs_d  = b_mag;
          if (b_zero) begin
            res_d   = in_rem ? A : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (sgn_ovf) begin
            res_d   = in_rem ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            rem_d   = 33'd0;
            quo_d   = a_mag;
            cnt_d   = 5'd0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = op_q[1] ? rem_res : quo_res;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      res_q   <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign finish = (state_q == DONE);
  assign busy   = (state_q != IDLE);
  assign res    = res_q;

endmodule

// File: tb/tb_fu_div_radix2.sv
// tb/tb_fu_div_radix2.sv - self-checking bench for fu_div_radix2
// Directed vector table, multi-cycle corner sequences, and random ops vs an arithmetic model.
module tb_fu_div_radix2;

  logic        clk;
  logic        rst;
  logic        EN;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        finish;
  logic        busy;
  logic [31:0] res;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  fu_div_radix2 dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (EN),
    .op     (op),
    .A      (A),
    .B      (B),
    .finish (finish),
    .busy   (busy),
    .res    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // RV32M semantics straight from the ISA rules, using native integer division
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'(sa / sb);
      2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10:   if (b == 0) return a; else if (ovf) return 32'd0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // lat counts rising edges after the EN edge until finish is seen high
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output logic busy_ok, output logic one_wide);
    @(negedge clk);
    EN = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    EN = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!finish && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    r = res;
    if (!busy) busy_ok = 1'b0;
    @(posedge clk); #1;
    one_wide = !finish;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    logic        bok;
    logic        wok;
    int          nfin;
    int          flat;
    logic [31:0] fres;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    int          elat;

    vecs[0]  = '{"div_100_7",      2'b00, 32'd100,         32'd7,           32'd14,          32};
    vecs[1]  = '{"rem_m100_7",     2'b10, 32'hFFFF_FF9C,   32'd7,           32'hFFFF_FFFE,   32};
    vecs[2]  = '{"div_m100_7",     2'b00, 32'hFFFF_FF9C,   32'd7,           32'hFFFF_FFF2,   32};
    vecs[3]  = '{"divu_max_2",     2'b01, 32'hFFFF_FFFF,   32'd2,           32'h7FFF_FFFF,   32};
    vecs[4]  = '{"remu_max_2",     2'b11, 32'hFFFF_FFFF,   32'd2,           32'd1,           32};
    vecs[5]  = '{"divu_5_0",       2'b01, 32'd5,           32'd0,           32'hFFFF_FFFF,   0};
    vecs[6]  = '{"rem_5_0",        2'b10, 32'd5,           32'd0,           32'd5,           0};
    vecs[7]  = '{"div_ovf",        2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   0};
    vecs[8]  = '{"rem_ovf",        2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           0};
    vecs[9]  = '{"divu_ovf_pat",   2'b01, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32};
    vecs[10] = '{"rem_m7_m2",      2'b10, 32'hFFFF_FFF9,   32'hFFFF_FFFE,   32'hFFFF_FFFF,   32};

    rst = 1'b0; EN = 1'b0; op = 2'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_finish", {31'd0, finish}, 32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_res",    res,             32'd0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bok, wok);
      check({vecs[i].name, "_res"}, r, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_busy"}, {31'd0, bok}, 32'd1);
      check({vecs[i].name, "_width"}, {31'd0, wok}, 32'd1);
    end

    // EN pulse mid-CALC must be ignored
    @(negedge clk);
    EN = 1'b1; op = 2'b00; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    EN = 1'b0;
    nfin = 0; flat = -1; fres = 32'd0;
    for (int k = 0; k < 60; k++) begin
      if (finish) begin
        if (nfin == 0) begin flat = k; fres = res; end
        nfin++;
      end
      if (k == 9) begin EN = 1'b1; op = 2'b00; A = 32'd9; B = 32'd3; end
      if (k == 10) EN = 1'b0;
      @(posedge clk); #1;
    end
    check("ign_res",   fres,          32'd333);
    check("ign_lat",   32'(flat),     32'd32);
    check("ign_nfin",  32'(nfin),     32'd1);

    // Reset mid-CALC abandons the operation
    @(negedge clk);
    EN = 1'b1; op = 2'b01; A = 32'd50; B = 32'd5;
    @(posedge clk); #1;
    EN = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k == 15) begin
        rst = 1'b0;
        #1;
        check("rst_busy_async", {31'd0, busy}, 32'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_res",  res,           32'd0);
    nfin = 0;
    for (int k = 0; k < 40; k++) begin
      if (finish) nfin++;
      @(posedge clk); #1;
    end
    check("rst_nofin", 32'(nfin), 32'd0);
    run_op(2'b01, 32'd50, 32'd5, r, lat, bok, wok);
    check("rst_fresh_res", r,          32'd10);
    check("rst_fresh_lat", 32'(lat),   32'd32);

    // Random operations vs the arithmetic model
    for (int i = 0; i < 60; i++) begin
      ro  = 2'($urandom);
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = $urandom_range(1, 15);
      else if (sel == 3) rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
      elat = ((rb == 0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 0 : 32;
      run_op(ro, ra, rb, r, lat, bok, wok);
      check($sformatf("rnd%0d_op%0d_%h_%h_res", i, ro, ra, rb), r, model(ro, ra, rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
